pi_scan_chain_ctrl: RTL and testbench
=====================================

Name: pi_scan_chain_ctrl

Overview:
- Scan-chain controller for the pi_pad column. It is the stage directly upstream of the pi_pad scan flops (drives their sc_in, scan enable and capture) and directly downstream of them (consumes the last pad's sc_out).
- Accepts a parallel word via valid/ready and optionally pulses a capture of the pads' functional inputs.
- Serially shifts the word into the chain while collecting the bits shifted out, then returns the collected word via valid/ready.

Parameters:
- CHAIN_LEN, 8, number of pi_pad scan flops in the chain; must be >= 1, otherwise an elaboration error is raised.
- CNT_W, $clog2(CHAIN_LEN+1), shift-counter width; derived, never overridden.

Ports:
- pi_scan_ctrl_clk  input  1  sole clock; rising edge; same clock as pi_pad_clk of the chain.
- pi_scan_ctrl_reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  controller can accept a command.
- cmd_capture  input  1  1 = perform one capture cycle before shifting.
- cmd_data  input  CHAIN_LEN  word to shift in; bit 0 is shifted first.
- scan_capture  output  1  to the chain's SC0; pads load their functional D.
- scan_se  output  1  to the chain's SE0/SE1; pads load DI (shift).
- scan_sc_in  output  1  to pi_pad_sc_in of the first pad.
- scan_sc_out  input  1  from pi_pad_sc_out of the last pad; a flop Q, stable all cycle.
- rsp_valid  output  1  collected word available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  CHAIN_LEN  collected word; bit i = i-th bit sampled from scan_sc_out.

Behaviour:
- FSM states: IDLE, CAPT, SHIFT, RESP. All outputs are registered except cmd_ready and rsp_valid, which are decoded from state.
- Reset (sync, any state, including mid-shift):
  - State goes to IDLE; counter = 0.
  - scan_se = 0, scan_capture = 0, scan_sc_in = 0, rsp_data = 0.
  - cmd_ready = 1, rsp_valid = 0.
  - Chain contents are undefined after reset; no partial response is emitted.
- IDLE:
  - cmd_ready = 1; scan_se = 0 and scan_capture = 0 (chain holds).
  - On cmd_valid & cmd_ready: latch cmd_data into the shift register and clear the counter.
  - Next state is CAPT if cmd_capture = 1, otherwise SHIFT.
- CAPT:
  - Exactly 1 cycle with scan_capture = 1 and scan_se = 0; then go to SHIFT.
- SHIFT:
  - Exactly CHAIN_LEN cycles with scan_se = 1 and scan_capture = 0.
  - Each cycle, scan_sc_in = the current shift-register bit (bit 0 first).
  - At each rising edge, sample scan_sc_out into rsp_data[count]; count++.
  - When count reaches CHAIN_LEN-1 at the edge, go to RESP.
- RESP:
  - rsp_valid = 1 and scan_se = 0. rsp_data is held stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE.
  - cmd_ready = 0 throughout RESP; the earliest next command is the cycle after the rsp handshake.
- Chain ordering after a shift:
  - cmd_data[0] ends in the last pad and cmd_data[CHAIN_LEN-1] in the first pad.
  - rsp_data[0] = prior content of the last pad; rsp_data[CHAIN_LEN-1] = prior content of the first pad.
- Latency: rsp_valid first rises CHAIN_LEN+2 cycles after the cmd handshake edge with capture, CHAIN_LEN+1 without.
- scan_se and scan_capture are never 1 simultaneously.
- cmd_valid while cmd_ready = 0 is ignored and not queued. cmd_data/cmd_capture are only sampled at handshake.
- CHAIN_LEN = 1: SHIFT lasts 1 cycle; the counter does not overflow.

Decomposition:
- Package pi_scan_pkg:
  - state enum typedef (IDLE/CAPT/SHIFT/RESP);
  - default CHAIN_LEN constant;
  - localparam function for CNT_W.
- One sub-module, pi_scan_shreg: CHAIN_LEN-bit load/shift-out register plus collect register with write index. The FSM and handshakes live in the top.

Test Plan:
- Bench model: 8-flop chain built from pi_pad-style flops (SE, SC, D, DI, Q).
- Reset, then cmd_data=8'hA5, cmd_capture=0 -> scan_se high exactly 8 cycles; chain holds A5 in documented order; rsp_data = prior chain content (00 after bench preload); rsp_valid at handshake+9.
- Bench pad D inputs = 8'h3C, cmd_capture=1, cmd_data=8'hFF -> scan_capture high 1 cycle, never overlapping scan_se; rsp_data=8'h3C; chain then holds FF; rsp_valid at handshake+10.
- Back-to-back: two cmds, rsp_ready held low 5 cycles -> rsp_data stable and cmd_ready=0 throughout; second cmd accepted the cycle after the rsp handshake; second rsp_data = first cmd_data (8'hA5).
- Reset asserted on the 4th SHIFT cycle -> next cycle: IDLE, cmd_ready=1, scan_se=0, rsp_valid=0; a following cmd completes normally with correct data.
- CHAIN_LEN=1 build: cmd_data=1, chain preloaded 0 -> exactly one scan_se cycle; rsp_data=0; chain=1; rsp_valid at handshake+2.

Source files
------------

// File: rtl/pi_scan_pkg.sv
// Shared types and constants for the pi_pad scan-chain controller.
package pi_scan_pkg;

  localparam int DEF_CHAIN_LEN = 8;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    SHIFT,
    RESP
  } state_e;

  // Counter must be able to hold CHAIN_LEN itself after the final shift.
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/pi_scan_chain_ctrl_if.sv
// Command, response and scan-chain signals of the pi_pad scan controller.
interface pi_scan_chain_ctrl_if
  import pi_scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_capture;
  logic [CHAIN_LEN-1:0] cmd_data;
  logic                 scan_capture;
  logic                 scan_se;
  logic                 scan_sc_in;
  logic                 scan_sc_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [CHAIN_LEN-1:0] rsp_data;

  // master: command source, response sink and the pad chain itself
  modport master (
    output cmd_valid, cmd_capture, cmd_data, rsp_ready, scan_sc_out,
    input  cmd_ready, rsp_valid, rsp_data, scan_capture, scan_se, scan_sc_in
  );

  modport slave (
    input  cmd_valid, cmd_capture, cmd_data, rsp_ready, scan_sc_out,
    output cmd_ready, rsp_valid, rsp_data, scan_capture, scan_se, scan_sc_in
  );

endinterface

// File: rtl/pi_scan_shreg.sv
// Load/shift-out register feeding the chain plus the collect register
// that gathers scan_sc_out bits at the current write index.
module pi_scan_shreg #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [CHAIN_LEN-1:0] load_data_i,
  input  logic                 shift_i,
  input  logic                 sc_in_en_i,
  input  logic                 sc_out_i,
  output logic                 sc_in_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic [CHAIN_LEN-1:0] col_data_o
);

  logic [CHAIN_LEN-1:0] sh_q, sh_d;
  logic [CHAIN_LEN-1:0] col_q, col_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sc_in_q;

  always_comb begin
    sh_d  = sh_q;
    col_d = col_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = load_data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sh_d = sh_q >> 1;
      for (int i = 0; i < CHAIN_LEN; i++) begin
        if (cnt_q == CNT_W'(i)) col_d[i] = sc_out_i;
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Shift data carries no reset; only what is visible outside is cleared.
  always_ff @(posedge clk_i) begin
    sh_q <= sh_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      col_q   <= '0;
      sc_in_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      sc_in_q <= sc_in_en_i & sh_d[0];
    end
  end

  assign sc_in_o    = sc_in_q;
  assign cnt_o      = cnt_q;
  assign col_data_o = col_q;

endmodule

// File: rtl/pi_scan_chain_ctrl.sv
// Scan-chain controller for the pi_pad column: optional capture, serial
// shift-in of a command word, and return of the bits shifted out.
module pi_scan_chain_ctrl
  import pi_scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic              pi_scan_ctrl_clk,
  input  logic              pi_scan_ctrl_reset,
  pi_scan_chain_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);

  if (CHAIN_LEN < 1) begin : g_len_chk
    $error("pi_scan_chain_ctrl: CHAIN_LEN must be >= 1");
  end

  state_e           state_q, state_d;
  logic             load, shift;
  logic             se_q, cap_q;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          load    = 1'b1;
          state_d = bus.cmd_capture ? CAPT : SHIFT;
        end
      end
      CAPT: state_d = SHIFT;
      SHIFT: begin
        shift = 1'b1;
        if (cnt == CNT_W'(CHAIN_LEN - 1)) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Chain controls are registered from the next state so they line up
  // with the cycle the FSM spends in CAPT/SHIFT.
  always_ff @(posedge pi_scan_ctrl_clk) begin
    if (pi_scan_ctrl_reset) begin
      state_q <= IDLE;
      se_q    <= 1'b0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      se_q    <= (state_d == SHIFT);
      cap_q   <= (state_d == CAPT);
    end
  end

  pi_scan_shreg #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_shreg (
    .clk_i       (pi_scan_ctrl_clk),
    .rst_i       (pi_scan_ctrl_reset),
    .load_i      (load),
    .load_data_i (bus.cmd_data),
    .shift_i     (shift),
    .sc_in_en_i  (state_d == SHIFT),
    .sc_out_i    (bus.scan_sc_out),
    .sc_in_o     (bus.scan_sc_in),
    .cnt_o       (cnt),
    .col_data_o  (bus.rsp_data)
  );

  assign bus.cmd_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.scan_se      = se_q;
  assign bus.scan_capture = cap_q;

endmodule

// File: tb/tb_pi_scan_chain_ctrl.sv
// Directed bench: 8-flop and 1-flop pi_pad-style chain models driven by two
// controller instances.
module tb_pi_scan_chain_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic preload_en;
  logic [7:0] pad_d;
  logic [7:0] chain8;
  logic       chain1;
  int checks = 0;
  int errors = 0;
  int se_cnt = 0, cap_cnt = 0, ovl_cnt = 0, se1_cnt = 0;

  always #5 clk = ~clk;

  pi_scan_chain_ctrl_if #(.CHAIN_LEN(8)) bus ();
  pi_scan_chain_ctrl_if #(.CHAIN_LEN(1)) bus1 ();

  pi_scan_chain_ctrl #(.CHAIN_LEN(8)) dut (
    .pi_scan_ctrl_clk   (clk),
    .pi_scan_ctrl_reset (rst),
    .bus                (bus)
  );

  pi_scan_chain_ctrl #(.CHAIN_LEN(1)) dut1 (
    .pi_scan_ctrl_clk   (clk),
    .pi_scan_ctrl_reset (rst),
    .bus                (bus1)
  );

  // pad k: DI from pad k-1 (pad 0 from sc_in), D from pad_d[k]; pad 7 is last
  always @(posedge clk) begin
    if (preload_en)               chain8 <= 8'h00;
    else if (bus.scan_se)         chain8 <= {chain8[6:0], bus.scan_sc_in};
    else if (bus.scan_capture)    chain8 <= pad_d;
    if (preload_en)               chain1 <= 1'b0;
    else if (bus1.scan_se)        chain1 <= bus1.scan_sc_in;
    else if (bus1.scan_capture)   chain1 <= 1'b0;
    if (bus.scan_se)                      se_cnt  <= se_cnt + 1;
    if (bus.scan_capture)                 cap_cnt <= cap_cnt + 1;
    if (bus.scan_se && bus.scan_capture)  ovl_cnt <= ovl_cnt + 1;
    if (bus1.scan_se)                     se1_cnt <= se1_cnt + 1;
  end

  assign bus.scan_sc_out  = chain8[7];
  assign bus1.scan_sc_out = chain1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] d, input logic cap);
    int t = 0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_data    = d;
    bus.cmd_capture = cap;
    while (!bus.cmd_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  int lat, se0, cap0, ovl0;

  initial begin
    rst = 1'b1; preload_en = 1'b1; pad_d = 8'h00;
    bus.cmd_valid = 1'b0; bus.cmd_capture = 1'b0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_capture = 1'b0; bus1.cmd_data = '0; bus1.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_se", bus.scan_se, 0);
    chk("rst_capture", bus.scan_capture, 0);
    chk("rst_sc_in", bus.scan_sc_in, 0);
    chk("rst_rsp_data", bus.rsp_data, 8'h00);
    chk("rst1_cmd_ready", bus1.cmd_ready, 1);
    rst = 1'b0; preload_en = 1'b0;
    @(posedge clk); #1;

    // plain shift of A5 into a zeroed chain
    se0 = se_cnt; cap0 = cap_cnt;
    send_cmd(8'hA5, 1'b0);
    wait_rsp(lat);
    chk("t1_latency", lat, 9);
    chk("t1_se_cycles", se_cnt - se0, 8);
    chk("t1_cap_cycles", cap_cnt - cap0, 0);
    chk("t1_rsp_data", bus.rsp_data, 8'h00);
    chk("t1_chain", chain8, 8'hA5);
    take_rsp();
    chk("t1_back_idle", bus.cmd_ready, 1);

    // capture 3C then shift FF
    pad_d = 8'h3C;
    se0 = se_cnt; cap0 = cap_cnt; ovl0 = ovl_cnt;
    send_cmd(8'hFF, 1'b1);
    wait_rsp(lat);
    chk("t2_latency", lat, 10);
    chk("t2_cap_cycles", cap_cnt - cap0, 1);
    chk("t2_se_cycles", se_cnt - se0, 8);
    chk("t2_overlap", ovl_cnt - ovl0, 0);
    chk("t2_rsp_data", bus.rsp_data, 8'h3C);
    chk("t2_chain", chain8, 8'hFF);
    take_rsp();

    // back-to-back with a stalled response
    send_cmd(8'hA5, 1'b0);
    wait_rsp(lat);
    chk("t3a_rsp_data", bus.rsp_data, 8'hFF);
    bus.cmd_valid = 1'b1; bus.cmd_data = 8'h1E; bus.cmd_capture = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t3_hold_data", bus.rsp_data, 8'hFF);
      chk("t3_hold_cmd_ready", bus.cmd_ready, 0);
      chk("t3_hold_rsp_valid", bus.rsp_valid, 1);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("t3_ready_after_rsp", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("t3_accepted", bus.cmd_ready, 0);
    chk("t3_shifting", bus.scan_se, 1);
    wait_rsp(lat);
    chk("t3b_latency", lat, 9);
    chk("t3b_rsp_data", bus.rsp_data, 8'hA5);
    chk("t3b_chain", chain8, 8'h78);
    take_rsp();

    // reset during the 4th shift cycle of 5A
    send_cmd(8'h5A, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_cmd_ready", bus.cmd_ready, 1);
    chk("t4_se", bus.scan_se, 0);
    chk("t4_rsp_valid", bus.rsp_valid, 0);
    chk("t4_capture", bus.scan_capture, 0);
    chk("t4_rsp_data", bus.rsp_data, 8'h00);
    chk("t4_chain_partial", chain8, 8'h85);
    se0 = se_cnt;
    send_cmd(8'h0F, 1'b0);
    wait_rsp(lat);
    chk("t4_latency", lat, 9);
    chk("t4_se_cycles", se_cnt - se0, 8);
    chk("t4_rsp_data_after", bus.rsp_data, 8'hA1);
    chk("t4_chain_after", chain8, 8'hF0);
    take_rsp();

    // single-flop chain
    se0 = se1_cnt;
    bus1.cmd_valid = 1'b1; bus1.cmd_data = 1'b1; bus1.cmd_capture = 1'b0;
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b0;
    lat = 1;
    while (!bus1.rsp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("t5_latency", lat, 2);
    chk("t5_se_cycles", se1_cnt - se0, 1);
    chk("t5_rsp_data", bus1.rsp_data, 0);
    chk("t5_chain", chain1, 1);
    bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.rsp_ready = 1'b0;
    chk("t5_back_idle", bus1.cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1);
  end

endmodule
